// File: rtl/wave_gen_pkg.sv
// Shared types and constant tables for the DDS waveform generator:
// waveform mode encoding, preset tuning words and quarter-sine samples.
package wave_gen_pkg;

    typedef enum logic [1:0] {
        WAVE_SAW  = 2'd0,
        WAVE_TRI  = 2'd1,
        WAVE_SQ   = 2'd2,
        WAVE_SINE = 2'd3
    } wave_mode_e;

    localparam int unsigned SEMITONES = 12;

    // Equal-tempered steps: ratio = 2^(n/12) in Q15, doubled once per octave.
    function automatic longint preset_word(input int unsigned idx, input int unsigned pw);
        longint ratio;
        case (idx % SEMITONES)
            0:       ratio = 64'sd32768;
            1:       ratio = 64'sd34716;
            2:       ratio = 64'sd36781;
            3:       ratio = 64'sd38968;
            4:       ratio = 64'sd41285;
            5:       ratio = 64'sd43740;
            6:       ratio = 64'sd46341;
            7:       ratio = 64'sd49097;
            8:       ratio = 64'sd52016;
            9:       ratio = 64'sd55109;
            10:      ratio = 64'sd58386;
            default: ratio = 64'sd61858;
        endcase
        return ((ratio << (idx / SEMITONES)) << pw) >> 29;
    endfunction

    // round(amp * sin(pi/2 * a / 2^aw)), integer Taylor series in Q30.
    function automatic int sine_quarter(input int unsigned a, input int unsigned aw,
                                        input int unsigned amp);
        longint x;
        longint term;
        longint sum;
        x    = (64'sd1686629713 * longint'(a)) >>> aw;
        term = x;
        sum  = x;
        for (int unsigned k = 1; k <= 5; k++) begin
            term = (term * x) >>> 30;
            term = (term * x) >>> 30;
            term = -term / longint'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        return int'((sum * longint'(amp) + 64'sd536870912) >>> 30);
    endfunction

endpackage

// File: rtl/wave_gen_dds_lut.sv
// Registered quarter-wave sine ROM (2^LUT_AW x DATA_W); its output register
// forms stage 1 of the sine path.
module sine_quarter_lut
    import wave_gen_pkg::*;
#(
    parameter int unsigned LUT_AW = 8,
    parameter int unsigned DATA_W = 11
) (
    input  logic              clk,
    input  logic [LUT_AW-1:0] addr,
    output logic [DATA_W-1:0] data
);

    localparam int unsigned DEPTH = 1 << LUT_AW;

    logic [DATA_W-1:0] rom [DEPTH];
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam logic [DATA_W-1:0] VAL =
            DATA_W'(sine_quarter(i, LUT_AW, (1 << DATA_W) - 1));
        assign rom[i] = VAL;
    end

    always_comb begin
        data_d = rom[addr];
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/wave_gen_dds.sv
// Phase-accumulator waveform generator (saw/tri/square/sine), 2-stage output pipe.
// Define SINE_LUT_EN to build the sine ROM; otherwise mode 3 produces the triangle.
module wave_gen_dds
    import wave_gen_pkg::*;
#(
    parameter int unsigned OUT_W      = 12,
    parameter int unsigned PHASE_W    = 24,
    parameter int unsigned LUT_AW     = 8,
    parameter int unsigned PRESET_N   = 49,
    parameter int unsigned PRESET_RST = 21
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        freq_up,
    input  logic                        freq_dn,
    input  logic                        tune_wr,
    input  logic [PHASE_W-1:0]          tune_val,
    input  logic [1:0]                  mode,
    output logic [OUT_W-1:0]            sig_out,
    output logic                        sig_valid,
    output logic                        wrap,
    output logic                        tune_pend,
    output logic [$clog2(PRESET_N)-1:0] preset_idx
);

    localparam int unsigned IDX_W = $clog2(PRESET_N);
    localparam logic [OUT_W-1:0] MIDSCALE = {1'b1, {(OUT_W-1){1'b0}}};

    logic [PHASE_W-1:0] preset_tbl [PRESET_N];

    for (genvar i = 0; i < PRESET_N; i++) begin : g_preset
        localparam logic [63:0] WORD = 64'(preset_word(i, PHASE_W));
        assign preset_tbl[i] = WORD[PHASE_W-1:0];
    end

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] tune_q, tune_d;
    logic [PHASE_W-1:0] pend_word_q, pend_word_d;
    logic               tune_pend_q, tune_pend_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               up_hist_q, up_hist_d;
    logic               dn_hist_q, dn_hist_d;
    logic               wrap_q, wrap_d;
    logic [OUT_W-1:0]   shape_q, shape_d;
    logic               valid1_q, valid1_d;
    logic               sig_valid_q, sig_valid_d;
    logic [OUT_W-1:0]   sig_out_q, sig_out_d;

    logic [PHASE_W:0]   phase_sum;
    logic               up_edge;
    logic               dn_edge;
    logic [OUT_W-1:0]   tri_base;
    wave_mode_e         mode_e;

    always_comb begin
        phase_sum   = {1'b0, phase_q} + {1'b0, tune_q};
        phase_d     = phase_sum[PHASE_W-1:0];
        wrap_d      = phase_sum[PHASE_W];
        up_hist_d   = freq_up;
        dn_hist_d   = freq_dn;
        up_edge     = freq_up & ~up_hist_q;
        dn_edge     = freq_dn & ~dn_hist_q;
        tune_d      = tune_q;
        pend_word_d = pend_word_q;
        tune_pend_d = tune_pend_q;
        idx_d       = idx_q;

        // Pending word is committed on the carry edge, so each period runs at one rate.
        if (wrap_d) begin
            if (tune_pend_q) begin
                tune_d = pend_word_q;
            end
            tune_pend_d = 1'b0;
        end

        if (tune_wr) begin
            pend_word_d = tune_val;
            tune_pend_d = 1'b1;
        end else if (up_edge != dn_edge) begin
            if (up_edge) begin
                idx_d = (idx_q == IDX_W'(PRESET_N - 1)) ? '0 : idx_q + IDX_W'(1);
            end else begin
                idx_d = (idx_q == '0) ? IDX_W'(PRESET_N - 1) : idx_q - IDX_W'(1);
            end
            pend_word_d = preset_tbl[idx_d];
            tune_pend_d = 1'b1;
        end
    end

    always_comb begin
        mode_e   = wave_mode_e'(mode);
        tri_base = phase_q[PHASE_W-2 -: OUT_W];
        case (mode_e)
            WAVE_SAW: shape_d = phase_q[PHASE_W-1 -: OUT_W];
            WAVE_SQ:  shape_d = {OUT_W{phase_q[PHASE_W-1]}};
            default:  shape_d = phase_q[PHASE_W-1] ? ~tri_base : tri_base;
        endcase
        valid1_d    = 1'b1;
        sig_valid_d = valid1_q;
    end

`ifdef SINE_LUT_EN
    logic [LUT_AW-1:0] lut_addr;
    logic [OUT_W-2:0]  lut_data;
    logic              sine_sel_q, sine_sel_d;
    logic              neg_q, neg_d;

    always_comb begin
        lut_addr   = phase_q[PHASE_W-2] ? ~phase_q[PHASE_W-3 -: LUT_AW]
                                        :  phase_q[PHASE_W-3 -: LUT_AW];
        sine_sel_d = (mode_e == WAVE_SINE);
        neg_d      = phase_q[PHASE_W-1];
        sig_out_d  = shape_q;
        if (sine_sel_q) begin
            sig_out_d = neg_q ? MIDSCALE - {1'b0, lut_data} : MIDSCALE + {1'b0, lut_data};
        end
    end

    sine_quarter_lut #(
        .LUT_AW (LUT_AW),
        .DATA_W (OUT_W - 1)
    ) u_lut (
        .clk  (clk),
        .addr (lut_addr),
        .data (lut_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sine_sel_q <= 1'b0;
            neg_q      <= 1'b0;
        end else begin
            sine_sel_q <= sine_sel_d;
            neg_q      <= neg_d;
        end
    end
`else
    always_comb begin
        sig_out_d = shape_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= '0;
            tune_q      <= preset_tbl[PRESET_RST];
            pend_word_q <= '0;
            tune_pend_q <= 1'b0;
            idx_q       <= IDX_W'(PRESET_RST);
            up_hist_q   <= 1'b0;
            dn_hist_q   <= 1'b0;
            wrap_q      <= 1'b0;
            shape_q     <= '0;
            valid1_q    <= 1'b0;
            sig_valid_q <= 1'b0;
            sig_out_q   <= '0;
        end else begin
            phase_q     <= phase_d;
            tune_q      <= tune_d;
            pend_word_q <= pend_word_d;
            tune_pend_q <= tune_pend_d;
            idx_q       <= idx_d;
            up_hist_q   <= up_hist_d;
            dn_hist_q   <= dn_hist_d;
            wrap_q      <= wrap_d;
            shape_q     <= shape_d;
            valid1_q    <= valid1_d;
            sig_valid_q <= sig_valid_d;
            sig_out_q   <= sig_out_d;
        end
    end

    assign sig_out    = sig_out_q;
    assign sig_valid  = sig_valid_q;
    assign wrap       = wrap_q;
    assign tune_pend  = tune_pend_q;
    assign preset_idx = idx_q;

endmodule

// File: tb/tb_wave_gen_dds.sv
// Directed self-checking bench for wave_gen_dds with hand-computed sample tables.
module tb_wave_gen_dds;

    typedef logic [11:0] vec16_t [16];

    localparam vec16_t SAW_EXP = '{12'h000, 12'h100, 12'h200, 12'h300, 12'h400, 12'h500,
                                   12'h600, 12'h700, 12'h800, 12'h900, 12'hA00, 12'hB00,
                                   12'hC00, 12'hD00, 12'hE00, 12'hF00};
    localparam vec16_t TRI_EXP = '{12'h000, 12'h200, 12'h400, 12'h600, 12'h800, 12'hA00,
                                   12'hC00, 12'hE00, 12'hFFF, 12'hDFF, 12'hBFF, 12'h9FF,
                                   12'h7FF, 12'h5FF, 12'h3FF, 12'h1FF};
    localparam vec16_t SQ_EXP  = '{12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000,
                                   12'h000, 12'h000, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF,
                                   12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};

    logic        clk = 1'b0;
    logic        rst;
    logic        freq_up;
    logic        freq_dn;
    logic        tune_wr;
    logic [23:0] tune_val;
    logic [1:0]  mode;
    logic [11:0] sig_out;
    logic        sig_valid;
    logic        wrap;
    logic        tune_pend;
    logic [5:0]  preset_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wave_gen_dds #(
        .OUT_W      (12),
        .PHASE_W    (24),
        .LUT_AW     (8),
        .PRESET_N   (49),
        .PRESET_RST (21)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .freq_up    (freq_up),
        .freq_dn    (freq_dn),
        .tune_wr    (tune_wr),
        .tune_val   (tune_val),
        .mode       (mode),
        .sig_out    (sig_out),
        .sig_valid  (sig_valid),
        .wrap       (wrap),
        .tune_pend  (tune_pend),
        .preset_idx (preset_idx)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_wrap(input int budget, output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (wrap !== 1'b1 && cycles < budget);
        if (wrap !== 1'b1) check_eq("wrap_timeout", 32'(wrap), 32'd1);
    endtask

    task automatic pulse_up();
        freq_up = 1'b1;
        step();
        freq_up = 1'b0;
        step();
    endtask

    // Align to a wrap, switch mode for the sample entering stage 1, compare one period.
    task automatic check_period(input string tag, input logic [1:0] m, input vec16_t exp);
        int n;
        wait_wrap(100, n);
        mode = m;
        step();
        step();
        for (int k = 0; k < 16; k++) begin
            check_eq($sformatf("%s[%0d]", tag, k), 32'(sig_out), 32'(exp[k]));
            step();
        end
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst      = 1'b1;
        freq_up  = 1'b0;
        freq_dn  = 1'b0;
        tune_wr  = 1'b0;
        tune_val = '0;
        mode     = 2'd0;
        repeat (3) step();

        check_eq("rst_sig_out",   32'(sig_out),    32'h0);
        check_eq("rst_sig_valid", 32'(sig_valid),  32'h0);
        check_eq("rst_wrap",      32'(wrap),       32'h0);
        check_eq("rst_tune_pend", 32'(tune_pend),  32'h0);
        check_eq("rst_idx",       32'(preset_idx), 32'd21);

        rst = 1'b0;
        step();
        check_eq("valid_cycle1", 32'(sig_valid), 32'h0);
        step();
        check_eq("valid_cycle2", 32'(sig_valid), 32'h1);

        // Test 1: custom tune, saw
        tune_val = 24'h100000;
        tune_wr  = 1'b1;
        step();
        tune_wr  = 1'b0;
        check_eq("pend_after_wr", 32'(tune_pend), 32'h1);
        wait_wrap(6000, n);
        check_eq("pend_cleared", 32'(tune_pend), 32'h0);
        step();
        step();
        for (int k = 0; k < 16; k++) begin
            check_eq($sformatf("saw[%0d]", k), 32'(sig_out), 32'(SAW_EXP[k]));
            step();
        end
        wait_wrap(40, n);
        wait_wrap(40, n);
        check_eq("period_16", 32'(n), 32'd16);

        // Tests 2, 3, 6
        check_period("tri", 2'd1, TRI_EXP);
        check_period("sq",  2'd2, SQ_EXP);
`ifdef SINE_LUT_EN
        wait_wrap(100, n);
        mode = 2'd3;
        step();
        step();
        for (int k = 0; k < 16; k++) begin
            case (k)
                0:  check_eq("sine_ph0",   32'(sig_out), 32'h800);
                2:  check_eq("sine_ph1_8", 32'(sig_out), 32'hDA7);
                4:  check_eq("sine_peak",  32'(sig_out), 32'hFFF);
                8:  check_eq("sine_half",  32'(sig_out), 32'h800);
                12: check_eq("sine_min",   32'(sig_out), 32'h001);
                default: ;
            endcase
            step();
        end
`else
        check_period("sine_as_tri", 2'd3, TRI_EXP);
`endif

        // Test 5: mid-period retune applies only after the wrap
        wait_wrap(100, n);
        mode = 2'd0;
        step();
        step();
        check_eq("t5_k0", 32'(sig_out), 32'h000);
        step();
        check_eq("t5_k1", 32'(sig_out), 32'h100);
        tune_val = 24'h200000;
        tune_wr  = 1'b1;
        step();
        tune_wr  = 1'b0;
        check_eq("t5_pend", 32'(tune_pend), 32'h1);
        for (int j = 2; j < 16; j++) begin
            check_eq($sformatf("t5_old[%0d]", j), 32'(sig_out), 32'(j) << 8);
            check_eq($sformatf("t5_wrap[%0d]", j), 32'(wrap), 32'(j == 14));
            step();
        end
        check_eq("t5_pend_clr", 32'(tune_pend), 32'h0);
        for (int m = 0; m < 8; m++) begin
            check_eq($sformatf("t5_new[%0d]", m), 32'(sig_out), 32'(m) << 9);
            step();
        end
        wait_wrap(40, n);
        wait_wrap(40, n);
        check_eq("period_8", 32'(n), 32'd8);

        // Test 4: preset stepping and wrap-around of the index
        repeat (27) pulse_up();
        check_eq("idx_48", 32'(preset_idx), 32'd48);
        pulse_up();
        check_eq("idx_up_wrap", 32'(preset_idx), 32'd0);
        check_eq("preset_pend", 32'(tune_pend), 32'h1);
        freq_dn = 1'b1;
        step();
        freq_dn = 1'b0;
        step();
        check_eq("idx_dn_wrap", 32'(preset_idx), 32'd48);
        freq_up = 1'b1;
        freq_dn = 1'b1;
        step();
        freq_up = 1'b0;
        freq_dn = 1'b0;
        step();
        check_eq("idx_both", 32'(preset_idx), 32'd48);
        tune_val = 24'h080000;
        tune_wr  = 1'b1;
        freq_up  = 1'b1;
        step();
        tune_wr  = 1'b0;
        freq_up  = 1'b0;
        step();
        check_eq("idx_wr_wins", 32'(preset_idx), 32'd48);
        freq_up = 1'b1;
        repeat (3) step();
        freq_up = 1'b0;
        step();
        check_eq("idx_level_held", 32'(preset_idx), 32'd0);

        // Mid-run reset
        rst = 1'b1;
        step();
        check_eq("rst2_sig_out",   32'(sig_out),    32'h0);
        check_eq("rst2_sig_valid", 32'(sig_valid),  32'h0);
        check_eq("rst2_wrap",      32'(wrap),       32'h0);
        check_eq("rst2_tune_pend", 32'(tune_pend),  32'h0);
        check_eq("rst2_idx",       32'(preset_idx), 32'd21);
        rst = 1'b0;
        step();
        step();
        check_eq("rst2_valid", 32'(sig_valid), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
